// File: rtl/hyperram_ui_pkg.sv
// Shared types and constants for the HyperRAM user-interface responder.
// Holds the FSM state encoding, the register-space addresses and the latency conversion.
package hyperram_ui_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAT,
      ST_WRITE,
      ST_READ,
      ST_DONE
   } state_e;

   localparam logic [31:0] REG_ID0 = 32'h0000_0000;
   localparam logic [31:0] REG_ID1 = 32'h0000_0001;
   localparam logic [31:0] REG_CR0 = 32'h0000_0800;
   localparam logic [31:0] REG_CR1 = 32'h0000_0801;

   localparam int unsigned CR0_FIXED_LAT_BIT = 3;

   // Latency is specified in clock edges; two edges make one clk cycle, rounded up.
   function automatic logic [7:0] lat_edges_to_cycles(input logic [7:0] edges);
      logic [8:0] sum;
      sum = {1'b0, edges} + 9'd1;
      return sum[8:1];
   endfunction

endpackage

// File: rtl/hyperram_ui_bram.sv
// Single-port 32-bit RAM with per-byte write enables and a one-cycle registered read.
// The read register only updates on a read enable, so it holds the last word otherwise.
module hyperram_ui_bram
   import hyperram_ui_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        we_i,
   input  logic              re_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/hyperram_ui_responder.sv
// Stand-in for the HyperRAM controller user interface: busy window, initial latency,
// burst reads from on-chip RAM, and an ID/CR register space.
module hyperram_ui_responder
   import hyperram_ui_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter logic [15:0] ID0_VAL = 16'h0C81,
   parameter logic [15:0] ID1_VAL = 16'h0001,
   parameter logic [15:0] CR0_RST = 16'h8F1F,
   parameter logic [15:0] CR1_RST = 16'hFFC1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic        mem_or_reg,
   input  logic [3:0]  wr_byte_en,
   input  logic [7:0]  rd_num_dwords,
   input  logic [31:0] addr,
   input  logic [31:0] wr_d,
   input  logic [7:0]  latency_1x,
   input  logic [7:0]  latency_2x,
   output logic [31:0] rd_d,
   output logic        rd_rdy,
   output logic        busy
);

   state_e            state_q;
   logic              busy_q;
   logic              rd_rdy_q;
   logic              is_wr_q;
   logic              is_reg_q;
   logic              sel_reg_q;
   logic [31:0]       addr_q;
   logic [31:0]       wr_d_q;
   logic [3:0]        be_q;
   logic [7:0]        lat_cnt_q;
   logic [7:0]        burst_cnt_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [15:0]       cr0_q;
   logic [15:0]       cr1_q;
   logic [15:0]       reg_rd_q;

   logic              accept;
   logic              lat_done;
   logic              ram_re;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_rdata;
   logic [7:0]        lat_sel;
   logic [15:0]       reg_val;

   assign accept   = (state_q == ST_IDLE) && !busy_q && (rd_req || wr_req);
   // The captured-request cycle (IDLE with busy set) counts as the slot before LAT.
   assign lat_done = (((state_q == ST_IDLE) && busy_q) || (state_q == ST_LAT)) &&
                     (lat_cnt_q == '0);

   always_comb begin
      lat_sel = latency_1x;
      if (wr_req && mem_or_reg) begin
         lat_sel = '0;
      end else if (!mem_or_reg && cr0_q[CR0_FIXED_LAT_BIT]) begin
         lat_sel = latency_2x;
      end
   end

   always_comb begin
      reg_val = '0;
      case (addr_q)
         REG_ID0: reg_val = ID0_VAL;
         REG_ID1: reg_val = ID1_VAL;
         REG_CR0: reg_val = cr0_q;
         REG_CR1: reg_val = cr1_q;
         default: reg_val = '0;
      endcase
   end

   // RAM reads are issued one cycle ahead of each rd_rdy so the read register lines up.
   assign ram_re   = !is_wr_q && !is_reg_q &&
                     ((lat_done && (burst_cnt_q != '0)) ||
                      ((state_q == ST_READ) && (burst_cnt_q != 8'd1)));
   assign ram_we   = ((state_q == ST_WRITE) && !is_reg_q) ? be_q : '0;
   assign ram_addr = (state_q == ST_WRITE) ? addr_q[ADDR_W-1:0] : rd_addr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         rd_rdy_q    <= 1'b0;
         is_wr_q     <= 1'b0;
         is_reg_q    <= 1'b0;
         sel_reg_q   <= 1'b0;
         addr_q      <= '0;
         wr_d_q      <= '0;
         be_q        <= '0;
         lat_cnt_q   <= '0;
         burst_cnt_q <= '0;
         rd_addr_q   <= '0;
         cr0_q       <= CR0_RST;
         cr1_q       <= CR1_RST;
         reg_rd_q    <= '0;
      end else begin
         rd_rdy_q <= 1'b0;
         if (ram_re) begin
            rd_addr_q <= rd_addr_q + 1'b1;
         end
         if (lat_done) begin
            if (is_wr_q) begin
               state_q <= ST_WRITE;
            end else if (burst_cnt_q == '0) begin
               state_q <= ST_DONE;
            end else begin
               state_q   <= ST_READ;
               rd_rdy_q  <= 1'b1;
               sel_reg_q <= is_reg_q;
               reg_rd_q  <= reg_val;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept) begin
                     busy_q      <= 1'b1;
                     is_wr_q     <= wr_req;
                     is_reg_q    <= mem_or_reg;
                     addr_q      <= addr;
                     rd_addr_q   <= addr[ADDR_W-1:0];
                     wr_d_q      <= wr_d;
                     be_q        <= wr_byte_en;
                     burst_cnt_q <= rd_num_dwords;
                     lat_cnt_q   <= lat_edges_to_cycles(lat_sel);
                  end else if (busy_q) begin
                     state_q   <= ST_LAT;
                     lat_cnt_q <= lat_cnt_q - 1'b1;
                  end
               end
               ST_LAT: begin
                  lat_cnt_q <= lat_cnt_q - 1'b1;
               end
               ST_WRITE: begin
                  if (is_reg_q && (be_q[1:0] == 2'b11)) begin
                     if (addr_q == REG_CR0) begin
                        cr0_q <= wr_d_q[15:0];
                     end else if (addr_q == REG_CR1) begin
                        cr1_q <= wr_d_q[15:0];
                     end
                  end
                  state_q <= ST_DONE;
               end
               ST_READ: begin
                  burst_cnt_q <= burst_cnt_q - 1'b1;
                  if (burst_cnt_q == 8'd1) begin
                     state_q <= ST_DONE;
                  end else begin
                     rd_rdy_q <= 1'b1;
                  end
               end
               ST_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   hyperram_ui_bram #(
      .ADDR_W(ADDR_W)
   ) u_bram (
      .clk_i   (clk),
      .rst_ni  (reset),
      .addr_i  (ram_addr),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .wdata_i (wr_d_q),
      .rdata_o (ram_rdata)
   );

   assign busy   = busy_q;
   assign rd_rdy = rd_rdy_q;
   assign rd_d   = sel_reg_q ? {16'h0000, reg_rd_q} : ram_rdata;

endmodule

// File: tb/tb_hyperram_ui_responder.sv
// Randomized bench for hyperram_ui_responder against a transaction-level reference model.
// Each transaction is predicted as busy length, rd_rdy timing and returned data words.
module tb_hyperram_ui_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   logic        wr_req;
   logic        mem_or_reg;
   logic [3:0]  wr_byte_en;
   logic [7:0]  rd_num_dwords;
   logic [31:0] addr;
   logic [31:0] wr_d;
   logic [7:0]  latency_1x;
   logic [7:0]  latency_2x;
   logic [31:0] rd_d;
   logic        rd_rdy;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_mem [DEPTH];
   logic [15:0] m_cr0;
   logic [15:0] m_cr1;
   logic [31:0] m_last_rd;

   always #5 clk = ~clk;

   hyperram_ui_responder #(
      .ADDR_W (AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rd_req        (rd_req),
      .wr_req        (wr_req),
      .mem_or_reg    (mem_or_reg),
      .wr_byte_en    (wr_byte_en),
      .rd_num_dwords (rd_num_dwords),
      .addr          (addr),
      .wr_d          (wr_d),
      .latency_1x    (latency_1x),
      .latency_2x    (latency_2x),
      .rd_d          (rd_d),
      .rd_rdy        (rd_rdy),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] reg_model(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0C81;
         32'h0000_0001: return 32'h0000_0001;
         32'h0000_0800: return {16'h0000, m_cr0};
         32'h0000_0801: return {16'h0000, m_cr1};
         default:       return 32'h0;
      endcase
   endfunction

   task automatic txn(input bit do_wr, input bit do_rd, input bit is_reg,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [7:0] n, input logic [7:0] l1, input logic [7:0] l2,
                      input bit poke);
      int lat_edges;
      int lat_cyc;
      int exp_busy;
      int busy_cnt;
      int first_rdy;
      int last_rdy;
      int unsigned ix;
      logic [31:0] exp_q[$];
      logic [31:0] got_q[$];

      // Reference prediction: a write wins over a simultaneous read.
      if (do_wr && is_reg)  lat_edges = 0;
      else if (is_reg)      lat_edges = int'(l1);
      else if (m_cr0[3])    lat_edges = int'(l2);
      else                  lat_edges = int'(l1);
      lat_cyc = (lat_edges + 1) / 2;
      if (do_wr) begin
         exp_busy = 1 + lat_cyc + 1 + 1;
      end else begin
         exp_busy = 1 + lat_cyc + int'(n) + 1;
         for (int i = 0; i < int'(n); i++) begin
            ix = ((a % DEPTH) + i) % DEPTH;
            exp_q.push_back(is_reg ? reg_model(a) : m_mem[ix]);
         end
      end

      rd_req = do_rd; wr_req = do_wr; mem_or_reg = is_reg; addr = a; wr_d = d;
      wr_byte_en = be; rd_num_dwords = n; latency_1x = l1; latency_2x = l2;
      busy_cnt = 0; first_rdy = -1; last_rdy = -1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
         end
         if (rd_rdy) begin
            if (first_rdy < 0) first_rdy = cyc;
            last_rdy = cyc;
            got_q.push_back(rd_d);
         end
         if (!busy) break;
         busy_cnt++;
         if (cyc == 1 && poke) begin
            wr_req = 1'b1; mem_or_reg = 1'b0; wr_byte_en = 4'hF; wr_d = ~d;
         end
         if (cyc == 2) wr_req = 1'b0;
      end
      rd_req = 1'b0;
      wr_req = 1'b0;

      chk("busy_len", busy_cnt, exp_busy);
      chk("rdy_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk("rd_data", got_q[i], exp_q[i]);
      end
      if (exp_q.size() > 0) begin
         chk("rdy_first", first_rdy, lat_cyc + 2);
         chk("rdy_last", last_rdy, lat_cyc + 1 + exp_q.size());
      end

      if (do_wr) begin
         if (is_reg) begin
            if (be[1:0] == 2'b11 && a == 32'h0000_0800) m_cr0 = d[15:0];
            if (be[1:0] == 2'b11 && a == 32'h0000_0801) m_cr1 = d[15:0];
         end else begin
            ix = a % DEPTH;
            for (int b = 0; b < 4; b++) begin
               if (be[b]) m_mem[ix][8*b +: 8] = d[8*b +: 8];
            end
         end
      end else if (exp_q.size() > 0) begin
         m_last_rd = exp_q[exp_q.size() - 1];
      end
      chk("rd_hold", rd_d, m_last_rd);
   endtask

   function automatic logic [31:0] pick_reg_addr();
      case ($urandom_range(4, 0))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'h0000_0800;
         3:       return 32'h0000_0801;
         default: return 32'h0000_0002;
      endcase
   endfunction

   initial begin
      bit          w;
      bit          r;
      bit          rg;
      logic [31:0] a;

      reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_or_reg = 1'b0; wr_byte_en = '0;
      rd_num_dwords = '0; addr = '0; wr_d = '0; latency_1x = '0; latency_2x = '0;
      m_cr0 = 16'h8F1F; m_cr1 = 16'hFFC1; m_last_rd = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_rdy", {31'b0, rd_rdy}, 32'd0);
      chk("reset_rd_d", rd_d, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < int'(DEPTH); i++) begin
         txn(1'b1, 1'b0, 1'b0, i, $urandom, 4'hF, 8'd0, 8'd0, 8'd0, 1'b0);
      end

      txn(1'b1, 1'b0, 1'b0, 32'd5, 32'hDEADBEEF, 4'hF, 8'd0, 8'd0, 8'd22, 1'b0);
      txn(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 4'h0, 8'd1, 8'd0, 8'd22, 1'b0);
      txn(1'b1, 1'b0, 1'b0, 32'd7, 32'h11223344, 4'hF, 8'd0, 8'd2, 8'd2, 1'b0);
      txn(1'b1, 1'b0, 1'b0, 32'd7, 32'hAABBCCDD, 4'b0101, 8'd0, 8'd2, 8'd2, 1'b0);
      txn(1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 4'h0, 8'd1, 8'd2, 8'd2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         txn(1'b1, 1'b0, 1'b0, (1021 + i) % DEPTH, i + 1, 4'hF, 8'd0, 8'd0, 8'd0, 1'b0);
      end
      txn(1'b0, 1'b1, 1'b0, 32'd1021, 32'd0, 4'h0, 8'd4, 8'd3, 8'd3, 1'b0);
      txn(1'b1, 1'b0, 1'b1, 32'h800, 32'h8F17, 4'h3, 8'd0, 8'd12, 8'd22, 1'b0);
      txn(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 4'h0, 8'd1, 8'd12, 8'd22, 1'b0);
      txn(1'b0, 1'b1, 1'b1, 32'h0, 32'd0, 4'h0, 8'd2, 8'd4, 8'd0, 1'b0);
      txn(1'b1, 1'b1, 1'b0, 32'd9, 32'hCAFEF00D, 4'hF, 8'd3, 8'd1, 8'd1, 1'b0);
      txn(1'b0, 1'b1, 1'b0, 32'd9, 32'h12345678, 4'h0, 8'd2, 8'd1, 8'd1, 1'b1);
      txn(1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 4'h0, 8'd0, 8'd5, 8'd5, 1'b0);

      repeat (200) begin
         w  = ($urandom_range(1, 0) == 1);
         r  = !w || ($urandom_range(9, 0) == 0);
         rg = ($urandom_range(3, 0) == 0);
         a  = rg ? pick_reg_addr() : $urandom;
         txn(w, r, rg, a, $urandom, 4'($urandom_range(15, 0)),
             8'($urandom_range(8, 0)), 8'($urandom_range(20, 0)),
             8'($urandom_range(20, 0)), ($urandom_range(4, 0) == 0));
      end

      rd_req = 1'b1; mem_or_reg = 1'b0; addr = 32'd100; rd_num_dwords = 8'd50;
      latency_1x = 8'd2; latency_2x = 8'd2;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_rdy", {31'b0, rd_rdy}, 32'd0);
      chk("midrst_rd_d", rd_d, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_cr0 = 16'h8F1F; m_cr1 = 16'hFFC1; m_last_rd = '0;
      @(negedge clk);
      txn(1'b0, 1'b1, 1'b1, 32'h800, 32'd0, 4'h0, 8'd1, 8'd2, 8'd2, 1'b0);
      txn(1'b0, 1'b1, 1'b0, 32'd1021, 32'd0, 4'h0, 8'd4, 8'd2, 8'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
